// File: rtl/timer_share_scheduler.sv
// Round-robin sharing of one interval-timer slave among NUM_REQ requesters.
// Optional abort support: define TIMER_SCHED_ABORT_EN.
module timer_share_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [32*NUM_REQ-1:0]  req_period,
    output logic [NUM_REQ-1:0]     done,
    output logic                   busy,
    output logic [ID_W-1:0]        grant_id,
    output logic [2:0]             t_address,
    output logic                   t_chipselect,
    output logic                   t_write_n,
    output logic [15:0]            t_writedata,
`ifdef TIMER_SCHED_ABORT_EN
    input  logic [NUM_REQ-1:0]     abort,
    output logic                   aborted,
`endif
    input  logic                   t_irq
);

    localparam int unsigned NUM_REQ_U = NUM_REQ;

    typedef enum logic [3:0] {
        IDLE,
        GRANT,
        WR_PL,
        WR_PH,
        GAP,
        WR_CTRL,
        WAIT_IRQ,
        CLR,
`ifdef TIMER_SCHED_ABORT_EN
        STOP,
`endif
        DONE
    } state_t;

    state_t          state_q, state_next;
    logic [ID_W-1:0] rr_q;
    logic [ID_W-1:0] grant_id_q;
    logic [31:0]     period_q;
    logic            any_req;
    logic [ID_W-1:0] pick;
    logic            own_abort;

    logic            wr_next;
    logic [2:0]      addr_next;
    logic [15:0]     data_next;

    // First requester at or after the rotating pointer, wrapping around.
    always_comb begin
        int unsigned idx;
        any_req = 1'b0;
        pick    = '0;
        for (int unsigned i = 0; i < NUM_REQ_U; i++) begin
            idx = (32'(rr_q) + i) % NUM_REQ_U;
            if (!any_req && ((req & (NUM_REQ'(1) << idx)) != '0)) begin
                any_req = 1'b1;
                pick    = ID_W'(idx);
            end
        end
    end

`ifdef TIMER_SCHED_ABORT_EN
    logic abort_flag_q;
    assign own_abort = (abort & (NUM_REQ'(1) << grant_id_q)) != '0;
`else
    assign own_abort = 1'b0;
`endif

    always_comb begin
        state_next = state_q;
        unique case (state_q)
            IDLE:     if (any_req) state_next = GRANT;
            GRANT:    state_next = (period_q == '0) ? DONE : WR_PL;
            WR_PL:    state_next = WR_PH;
            WR_PH:    state_next = GAP;
            GAP:      state_next = WR_CTRL;
            WR_CTRL:  state_next = WAIT_IRQ;
            WAIT_IRQ: if (t_irq) state_next = CLR;
            CLR:      state_next = DONE;
`ifdef TIMER_SCHED_ABORT_EN
            STOP:     state_next = CLR;
`endif
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
`ifdef TIMER_SCHED_ABORT_EN
        // The write currently on the bus always completes before STOP is issued.
        if (own_abort && (state_q == WR_PL || state_q == WR_PH || state_q == GAP ||
                          state_q == WR_CTRL || state_q == WAIT_IRQ))
            state_next = STOP;
`endif
    end

    // Timer-port values are decoded from the next state and registered.
    always_comb begin
        wr_next   = 1'b0;
        addr_next = '0;
        data_next = '0;
        unique case (state_next)
            WR_PL: begin
                wr_next   = 1'b1;
                addr_next = 3'd2;
                data_next = period_q[15:0];
            end
            WR_PH: begin
                wr_next   = 1'b1;
                addr_next = 3'd3;
                data_next = period_q[31:16];
            end
            WR_CTRL: begin
                wr_next   = 1'b1;
                addr_next = 3'd1;
                data_next = 16'h0005;
            end
`ifdef TIMER_SCHED_ABORT_EN
            STOP: begin
                wr_next   = 1'b1;
                addr_next = 3'd1;
                data_next = 16'h0008;
            end
`endif
            CLR: begin
                wr_next   = 1'b1;
                addr_next = 3'd0;
                data_next = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            rr_q         <= '0;
            grant_id_q   <= '0;
            period_q     <= '0;
            done         <= '0;
            busy         <= 1'b0;
            t_chipselect <= 1'b0;
            t_write_n    <= 1'b1;
            t_address    <= '0;
            t_writedata  <= '0;
        end else begin
            state_q      <= state_next;
            t_chipselect <= wr_next;
            t_write_n    <= ~wr_next;
            t_address    <= addr_next;
            t_writedata  <= data_next;
            busy         <= (state_next != IDLE);
            done         <= (state_next == DONE) ? (NUM_REQ'(1) << grant_id_q) : '0;
            if (state_q == IDLE && any_req) begin
                grant_id_q <= pick;
                period_q   <= 32'(req_period >> (32 * 32'(pick)));
            end
            if (state_q == DONE) begin
                if (grant_id_q == ID_W'(NUM_REQ - 1))
                    rr_q <= '0;
                else
                    rr_q <= grant_id_q + 1'b1;
            end
        end
    end

`ifdef TIMER_SCHED_ABORT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            abort_flag_q <= 1'b0;
            aborted      <= 1'b0;
        end else begin
            if (state_next == STOP)
                abort_flag_q <= 1'b1;
            else if (state_q == IDLE)
                abort_flag_q <= 1'b0;
            aborted <= (state_next == DONE) && abort_flag_q;
        end
    end
`endif

    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_timer_share_scheduler.sv
// Directed bench for timer_share_scheduler with a behavioural interval-timer model.
module tb_timer_share_scheduler;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [3:0]   req = '0;
    logic [127:0] req_period = '0;
    logic [3:0]   done;
    logic         busy;
    logic [1:0]   grant_id;
    logic [2:0]   t_address;
    logic         t_chipselect;
    logic         t_write_n;
    logic [15:0]  t_writedata;
    logic         t_irq;
`ifdef TIMER_SCHED_ABORT_EN
    logic [3:0]   abort = '0;
    logic         aborted;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [18:0] wlog[$];

    timer_share_scheduler #(.NUM_REQ(4), .ID_W(2)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req          (req),
        .req_period   (req_period),
        .done         (done),
        .busy         (busy),
        .grant_id     (grant_id),
        .t_address    (t_address),
        .t_chipselect (t_chipselect),
        .t_write_n    (t_write_n),
        .t_writedata  (t_writedata),
`ifdef TIMER_SCHED_ABORT_EN
        .abort        (abort),
        .aborted      (aborted),
`endif
        .t_irq        (t_irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk)
        if (reset_n && t_chipselect && !t_write_n)
            wlog.push_back({t_address, t_writedata});

    // Timer model: one-shot countdown, irq held until a write to status.
    logic [15:0] m_pl, m_ph;
    logic [31:0] m_cnt;
    logic        m_run, m_irq;
    assign t_irq = m_irq;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pl <= '0; m_ph <= '0; m_cnt <= '0; m_run <= 1'b0; m_irq <= 1'b0;
        end else begin
            if (m_run) begin
                if (m_cnt == 0) begin m_irq <= 1'b1; m_run <= 1'b0; end
                else m_cnt <= m_cnt - 1;
            end
            if (t_chipselect && !t_write_n) begin
                case (t_address)
                    3'd0: m_irq <= 1'b0;
                    3'd2: m_pl <= t_writedata;
                    3'd3: m_ph <= t_writedata;
                    3'd1: begin
                        if (t_writedata[3]) m_run <= 1'b0;
                        else if (t_writedata[2]) begin m_cnt <= {m_ph, m_pl}; m_run <= 1'b1; end
                    end
                    default: ;
                endcase
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int maxc, output int idx, output bit ok);
        ok  = 1'b0;
        idx = -1;
        for (int c = 0; c < maxc; c++) begin
            @(negedge clk);
            if (done != '0) begin
                ok = 1'b1;
                for (int k = 0; k < 4; k++) if (done[k]) idx = k;
                break;
            end
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string pfx);
        check({pfx, "_done"}, 32'(done), 32'h0);
        check({pfx, "_busy"}, 32'(busy), 32'h0);
        check({pfx, "_gid"},  32'(grant_id), 32'h0);
        check({pfx, "_cs"},   32'(t_chipselect), 32'h0);
        check({pfx, "_wn"},   32'(t_write_n), 32'h1);
        check({pfx, "_addr"}, 32'(t_address), 32'h0);
        check({pfx, "_data"}, 32'(t_writedata), 32'h0);
    endtask

    task automatic check_writes(input string pfx, input int first, input logic [18:0] e0,
                                input logic [18:0] e1, input logic [18:0] e2, input logic [18:0] e3);
        logic [18:0] exp [4];
        exp = '{e0, e1, e2, e3};
        for (int i = 0; i < 4; i++)
            check($sformatf("%s_wr%0d", pfx, i),
                  (first + i < wlog.size()) ? 32'(wlog[first + i]) : 32'hFFFF_FFFF, 32'(exp[i]));
    endtask

    initial begin
        int  idx;
        bit  ok;
        int  t0;
        int  order [5];

        order = '{0, 1, 2, 3, 0};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check_idle_outputs("rst");
        reset_n = 1'b1;
        @(negedge clk);

        // Single request, period 20
        wlog.delete();
        req_period[31:0] = 32'd20;
        req = 4'b0001;
        wait_done(200, idx, ok);
        req = '0;
        check("t1_done_seen", 32'(ok), 32'h1);
        check("t1_done", 32'(done), 32'h1);
        check("t1_busy_at_done", 32'(busy), 32'h1);
        check_writes("t1", 0, {3'd2, 16'h0014}, {3'd3, 16'h0000}, {3'd1, 16'h0005}, {3'd0, 16'h0000});
        check("t1_nwr", 32'(wlog.size()), 32'd4);
        @(negedge clk);
        check("t1_done_off", 32'(done), 32'h0);
        check("t1_busy_off", 32'(busy), 32'h0);

        // All four requesting continuously, from pointer 0
        do_reset();
        req_period = {4{32'd5}};
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_done(100, idx, ok);
            check($sformatf("t2_seen%0d", g), 32'(ok), 32'h1);
            check($sformatf("t2_order%0d", g), 32'(idx), 32'(order[g]));
            check($sformatf("t2_gid%0d", g), 32'(grant_id), 32'(order[g]));
        end
        req = '0;
        @(negedge clk);

        // Zero period: no timer access, done in third cycle
        do_reset();
        wlog.delete();
        req_period = '0;
        req = 4'b0100;
        @(negedge clk);
        check("t3_busy", 32'(busy), 32'h1);
        check("t3_gid", 32'(grant_id), 32'h2);
        check("t3_early", 32'(done), 32'h0);
        @(negedge clk);
        req = '0;
        check("t3_done", 32'(done), 32'h4);
        check("t3_cs", 32'(t_chipselect), 32'h0);
        @(negedge clk);
        check("t3_busy_off", 32'(busy), 32'h0);
        check("t3_nwr", 32'(wlog.size()), 32'd0);

        // Period spanning both halves
        wlog.delete();
        req_period[31:0] = 32'h0001_0003;
        req = 4'b0001;
        t0 = cyc;
        wait_done(70000, idx, ok);
        req = '0;
        check("t4_done_seen", 32'(ok), 32'h1);
        check("t4_done", 32'(done), 32'h1);
        check_writes("t4", 0, {3'd2, 16'h0003}, {3'd3, 16'h0001}, {3'd1, 16'h0005}, {3'd0, 16'h0000});
        check("t4_latency", 32'((cyc - t0) >= 65539 && (cyc - t0) <= 65560), 32'h1);
        @(negedge clk);

        // Reset while waiting for irq
        wlog.delete();
        req_period[95:64] = 32'd1000;
        req = 4'b0100;
        for (int c = 0; c < 40 && wlog.size() < 3; c++) @(negedge clk);
        repeat (5) @(negedge clk);
        check("t5_busy_pre", 32'(busy), 32'h1);
        check("t5_gid_pre", 32'(grant_id), 32'h2);
        reset_n = 1'b0;
        #1;
        check_idle_outputs("t5");
        req = '0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        req_period[31:0] = '0;
        req = 4'b1001;
        @(negedge clk);
        check("t5_restart_gid", 32'(grant_id), 32'h0);
        req = '0;
        wait_done(20, idx, ok);
        check("t5_restart_done", 32'(idx), 32'h0);
        @(negedge clk);

`ifdef TIMER_SCHED_ABORT_EN
        // Abort by owner during WAIT_IRQ; abort by non-owner ignored
        do_reset();
        wlog.delete();
        req_period[63:32] = 32'd1000;
        req = 4'b0010;
        for (int c = 0; c < 40 && wlog.size() < 3; c++) @(negedge clk);
        abort = 4'b0001;
        repeat (3) @(negedge clk);
        check("t6_nonowner_busy", 32'(busy), 32'h1);
        check("t6_nonowner_nwr", 32'(wlog.size()), 32'd3);
        abort = 4'b0010;
        wait_done(20, idx, ok);
        abort = '0;
        req = '0;
        check("t6_done", 32'(done), 32'h2);
        check("t6_aborted", 32'(aborted), 32'h1);
        check("t6_nwr", 32'(wlog.size()), 32'd5);
        check_writes("t6", 1, {3'd3, 16'h0000}, {3'd1, 16'h0005}, {3'd1, 16'h0008}, {3'd0, 16'h0000});
        @(negedge clk);
        check("t6_aborted_off", 32'(aborted), 32'h0);
        check("t6_done_off", 32'(done), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
